// File: rtl/sp_ram_req_seq_512x16_pkg.sv
// Shared widths, sweep depth and FSM encoding for the 512x16 RAM request sequencer.
package sp_ram_seq_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        SERVE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sp_ram_req_seq_512x16_if.sv
// Request/response stream bundle between a client (master) and the sequencer (slave).
interface sp_ram_req_seq_512x16_if
    import sp_ram_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/sp_ram_req_seq_512x16_rsp_fifo.sv
// Two-entry response buffer; head is a register so rsp_data is glitch-free and stable under stall.
module sp_ram_rsp_fifo
    import sp_ram_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [1:0]        occ,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] slot1;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ   <= 2'd0;
            head  <= '0;
            slot1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= din;
                    else             slot1 <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    if (occ != 2'd0) begin
                        head <= slot1;
                        occ  <= occ - 2'd1;
                    end
                end
                2'b11: begin
                    // simultaneous push/pop keeps occupancy; the older word moves to the head
                    if (occ == 2'd2) begin
                        head  <= slot1;
                        slot1 <= din;
                    end else begin
                        head <= din;
                    end
                    if (occ == 2'd0) occ <= 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sp_ram_req_seq_512x16.sv
// Init sweep + request/response sequencer in front of a 512x16 write-first single-port RAM.
module sp_ram_req_seq_512x16
    import sp_ram_seq_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                DEPTH    = DEPTH_DEF,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      init_start,
    output logic                      init_busy,
    sp_ram_req_seq_512x16_if.slave    bus,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic                      ram_rst,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_di,
    input  logic [DATA_W-1:0]         ram_dout
);

    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W:0]   cnt;
    logic              inflight;
    logic [1:0]        occ;
    logic [2:0]        used;
    logic              pop;
    logic              ready;
    logic              accept;
    logic [DATA_W-1:0] head;

    // Credit: an issue is allowed only if the buffer can hold its result, counting this cycle's pop.
    assign pop    = bus.rsp_valid && bus.rsp_ready;
    assign used   = {1'b0, occ} + {2'b00, inflight};
    assign ready  = !rst && (state == SERVE) && (used < (3'd2 + {2'b00, pop}));
    assign accept = bus.req_valid && ready;

    assign bus.req_ready = ready;
    assign bus.rsp_valid = !rst && (occ != 2'd0);
    assign bus.rsp_data  = head;

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            INIT:    if (cnt == LAST) state_nx = SERVE;
            SERVE:   if (init_start) state_nx = DRAIN;
            DRAIN:   if (occ == 2'd0 && !inflight) state_nx = INIT;
            default: state_nx = INIT;
        endcase
    end

    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_rst  = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        if (rst) begin
            ram_en  = 1'b1;
            ram_rst = 1'b1;
        end else begin
            case (state)
                INIT: begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = cnt[ADDR_W-1:0];
                    ram_di   = INIT_VAL;
                end
                SERVE: begin
                    if (accept) begin
                        ram_en   = 1'b1;
                        ram_we   = bus.req_we;
                        ram_addr = bus.req_addr;
                        ram_di   = bus.req_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Issue stage -> RAM output stage: inflight marks ram_dout as valid next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            inflight  <= 1'b0;
            init_busy <= 1'b1;
        end else begin
            cnt       <= (state == INIT) ? cnt + 1'b1 : '0;
            inflight  <= accept;
            init_busy <= (state_nx != SERVE);
        end
    end

    // RAM output stage -> response buffer.
    sp_ram_rsp_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .pop  (pop),
        .din  (ram_dout),
        .occ  (occ),
        .head (head)
    );

endmodule
